// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage operand/hazard bundle between control path and hazard scoreboard
// master: drives ID instruction info and branch resolution, receives forward selects, enables, counters
// slave: the scoreboard side
interface hazard_scoreboard_if #(
   parameter int NUM_SRC    = 3,
   parameter int REG_AW     = 4,
   parameter int FWD_STAGES = 3,
   parameter int CNT_W      = 16
);
   localparam int SEL_W = $clog2(FWD_STAGES + 1);
   logic                      id_valid;
   logic                      id_rf_en;
   logic                      id_load;
   logic [REG_AW-1:0]         id_rd;
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [NUM_SRC-1:0]        id_rs_used;
   logic                      ex_branch_taken;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
   logic                      pc_le;
   logic                      ifid_le;
   logic                      nop_sel;
   logic                      ifid_flush;
   logic [CNT_W-1:0]          stall_cnt;
   logic [CNT_W-1:0]          flush_cnt;
   modport master (
      output id_valid, id_rf_en, id_load, id_rd, id_rs, id_rs_used, ex_branch_taken,
      input  fwd_sel, pc_le, ifid_le, nop_sel, ifid_flush, stall_cnt, flush_cnt
   );
   modport slave (
      input  id_valid, id_rf_en, id_load, id_rd, id_rs, id_rs_used, ex_branch_taken,
      output fwd_sel, pc_le, ifid_le, nop_sel, ifid_flush, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shifting EX..WB destination scoreboard driving forwarding, load-use stall and branch flush
// CLK: rising-edge clock; CLR: asynchronous active-low reset
// bus (slave): ID instruction info + branch in; fwd_sel, pc_le, ifid_le, nop_sel, ifid_flush, event counters out
module hazard_scoreboard #(
   parameter int NUM_SRC        = 3,
   parameter int REG_AW         = 4,
   parameter int FWD_STAGES     = 3,
   parameter int LOAD_MIN_STAGE = 1,
   parameter int FWD_EN         = 1,
   parameter int PC_REG         = 15,
   parameter int CNT_W          = 16
) (
   input logic                CLK,
   input logic                CLR,
   hazard_scoreboard_if.slave bus
);
   localparam int SEL_W = $clog2(FWD_STAGES + 1);
   logic [FWD_STAGES-1:0]    v_q, v_d, rf_q, rf_d, ld_q, ld_d;
   logic [REG_AW-1:0]        rd_q [FWD_STAGES];
   logic [REG_AW-1:0]        rd_d [FWD_STAGES];
   logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic [NUM_SRC-1:0]       haz;
   logic [NUM_SRC*SEL_W-1:0] sel;
   logic [REG_AW-1:0]        rs;
   logic                     hit, hit_ld, stall, push, br;
   int                       idx;
   assign br = bus.ex_branch_taken;
   // scan oldest to youngest so the youngest matching entry is the one left standing
   always_comb begin
      haz = '0;
      sel = '0;
      rs = '0;
      hit = 1'b0;
      hit_ld = 1'b0;
      idx = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         rs = bus.id_rs[k*REG_AW +: REG_AW];
         hit = 1'b0;
         hit_ld = 1'b0;
         idx = 0;
         for (int i = FWD_STAGES - 1; i >= 0; i--)
            if (bus.id_rs_used[k] && rs != REG_AW'(PC_REG) && v_q[i] && rf_q[i] && rd_q[i] == rs) begin
               hit = 1'b1;
               hit_ld = ld_q[i];
               idx = i;
            end
         haz[k] = (FWD_EN != 0) ? (hit & hit_ld & (idx < LOAD_MIN_STAGE)) : hit;
         sel[k*SEL_W +: SEL_W] = (FWD_EN != 0 && hit && !haz[k]) ? SEL_W'(idx + 1) : '0;
      end
   end
   // a taken branch kills the ID instruction, so it also cancels any stall it would cause
   assign stall = bus.id_valid & (|haz) & ~br;
   assign push  = bus.id_valid & ~stall & ~br;
   always_comb begin
      v_d  = (v_q << 1) | FWD_STAGES'(push);
      rf_d = (rf_q << 1) | FWD_STAGES'(push & bus.id_rf_en);
      ld_d = (ld_q << 1) | FWD_STAGES'(push & bus.id_load);
      rd_d[0] = bus.id_rd;
      for (int i = 1; i < FWD_STAGES; i++) rd_d[i] = rd_q[i-1];
      stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (br && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end
   always_ff @(posedge CLK or negedge CLR)
      if (!CLR) begin
         v_q <= '0;
         rf_q <= '0;
         ld_q <= '0;
         rd_q <= '{default: '0};
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         v_q <= v_d;
         rf_q <= rf_d;
         ld_q <= ld_d;
         rd_q <= rd_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   assign bus.fwd_sel    = sel;
   assign bus.pc_le      = ~stall;
   assign bus.ifid_le    = ~stall;
   assign bus.nop_sel    = stall | br;
   assign bus.ifid_flush = br;
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, stall-only and saturating-counter configurations
module tb_hazard_scoreboard;
   logic CLK = 1'b0;
   logic CLR = 1'b0;
   int   errors = 0;
   int   checks = 0;
   always #5 CLK = ~CLK;
   hazard_scoreboard_if ia ();
   hazard_scoreboard_if ib ();
   hazard_scoreboard_if #(.FWD_STAGES(5), .CNT_W(2)) ic ();
   hazard_scoreboard dut_a (.CLK(CLK), .CLR(CLR), .bus(ia));
   hazard_scoreboard #(.FWD_EN(0)) dut_b (.CLK(CLK), .CLR(CLR), .bus(ib));
   hazard_scoreboard #(.FWD_EN(0), .FWD_STAGES(5), .CNT_W(2)) dut_c (.CLK(CLK), .CLR(CLR), .bus(ic));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // drive one DUT (d = 0/1/2) with an ID instruction; the other two see idle inputs
   task automatic drive(input int d, input logic v, input logic rf, input logic ld, input logic [3:0] rd,
                        input logic [11:0] rs, input logic [2:0] used, input logic br);
      ia.id_valid = (d == 0) ? v : 1'b0;
      ia.id_rf_en = (d == 0) ? rf : 1'b0;
      ia.id_load = (d == 0) ? ld : 1'b0;
      ia.id_rd = (d == 0) ? rd : 4'd0;
      ia.id_rs = (d == 0) ? rs : 12'd0;
      ia.id_rs_used = (d == 0) ? used : 3'd0;
      ia.ex_branch_taken = (d == 0) ? br : 1'b0;
      ib.id_valid = (d == 1) ? v : 1'b0;
      ib.id_rf_en = (d == 1) ? rf : 1'b0;
      ib.id_load = (d == 1) ? ld : 1'b0;
      ib.id_rd = (d == 1) ? rd : 4'd0;
      ib.id_rs = (d == 1) ? rs : 12'd0;
      ib.id_rs_used = (d == 1) ? used : 3'd0;
      ib.ex_branch_taken = (d == 1) ? br : 1'b0;
      ic.id_valid = (d == 2) ? v : 1'b0;
      ic.id_rf_en = (d == 2) ? rf : 1'b0;
      ic.id_load = (d == 2) ? ld : 1'b0;
      ic.id_rd = (d == 2) ? rd : 4'd0;
      ic.id_rs = (d == 2) ? rs : 12'd0;
      ic.id_rs_used = (d == 2) ? used : 3'd0;
      ic.ex_branch_taken = (d == 2) ? br : 1'b0;
      #2;
   endtask
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask
   initial begin
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_fwd_sel", 32'(ia.fwd_sel), 0);
      chk("rst_pc_le", 32'(ia.pc_le), 1);
      chk("rst_ifid_le", 32'(ia.ifid_le), 1);
      chk("rst_nop_sel", 32'(ia.nop_sel), 0);
      chk("rst_flush", 32'(ia.ifid_flush), 0);
      chk("rst_stall_cnt", 32'(ia.stall_cnt), 0);
      chk("rst_flush_cnt", 32'(ia.flush_cnt), 0);
      #1 CLR = 1'b1;
      tick(1);
      // ADD R1 ; ADD R2,R1,R3 ; consumer of R1
      drive(0, 1, 1, 0, 4'd1, 12'h000, 3'b000, 0);
      tick(1);
      drive(0, 1, 1, 0, 4'd2, 12'h031, 3'b011, 0);
      chk("alu_fwd_ex", 32'(ia.fwd_sel), 1);
      chk("alu_no_stall", 32'(ia.pc_le), 1);
      tick(1);
      drive(0, 1, 1, 0, 4'd5, 12'h001, 3'b001, 0);
      chk("alu_fwd_mem", 32'(ia.fwd_sel), 2);
      tick(1);
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      tick(3);
      // LDR R2 ; ADD R4,R2,R2
      drive(0, 1, 1, 1, 4'd2, 12'h000, 3'b000, 0);
      tick(1);
      drive(0, 1, 1, 0, 4'd4, 12'h022, 3'b011, 0);
      chk("lu_pc_le", 32'(ia.pc_le), 0);
      chk("lu_ifid_le", 32'(ia.ifid_le), 0);
      chk("lu_nop_sel", 32'(ia.nop_sel), 1);
      chk("lu_fwd_sel", 32'(ia.fwd_sel), 0);
      tick(1);
      chk("lu_stall_cnt", 32'(ia.stall_cnt), 1);
      chk("lu_fwd_after", 32'(ia.fwd_sel), 10);
      chk("lu_pc_le_after", 32'(ia.pc_le), 1);
      chk("lu_nop_after", 32'(ia.nop_sel), 0);
      tick(1);
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      tick(3);
      // load-use collides with a taken branch
      drive(0, 1, 1, 1, 4'd2, 12'h000, 3'b000, 0);
      tick(1);
      drive(0, 1, 1, 0, 4'd4, 12'h002, 3'b001, 1);
      chk("br_flush", 32'(ia.ifid_flush), 1);
      chk("br_nop_sel", 32'(ia.nop_sel), 1);
      chk("br_pc_le", 32'(ia.pc_le), 1);
      chk("br_ifid_le", 32'(ia.ifid_le), 1);
      tick(1);
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      chk("br_flush_cnt", 32'(ia.flush_cnt), 1);
      chk("br_stall_cnt", 32'(ia.stall_cnt), 1);
      tick(3);
      // R15 writer and R3 writer; consumer reads R15 and an unused R3
      drive(0, 1, 1, 0, 4'd15, 12'h000, 3'b000, 0);
      tick(1);
      drive(0, 1, 1, 0, 4'd3, 12'h000, 3'b000, 0);
      tick(1);
      drive(0, 1, 1, 0, 4'd8, 12'h03F, 3'b001, 0);
      chk("pc_fwd_sel", 32'(ia.fwd_sel), 0);
      chk("pc_no_stall", 32'(ia.pc_le), 1);
      drive(0, 1, 1, 0, 4'd8, 12'h03F, 3'b010, 0);
      chk("used_src1_fwd", 32'(ia.fwd_sel), 4);
      tick(1);
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      tick(3);
      // two writers of R6: youngest wins
      drive(0, 1, 1, 0, 4'd6, 12'h000, 3'b000, 0);
      tick(2);
      drive(0, 1, 1, 0, 4'd9, 12'h006, 3'b001, 0);
      chk("youngest_wins", 32'(ia.fwd_sel), 1);
      tick(1);
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      tick(3);
      // stall-only: MOV R1 ; consumer of R1
      drive(1, 1, 1, 0, 4'd1, 12'h000, 3'b000, 0);
      tick(1);
      drive(1, 1, 1, 0, 4'd7, 12'h001, 3'b001, 0);
      chk("so_stall_ex", 32'(ib.pc_le), 0);
      chk("so_fwd_ex", 32'(ib.fwd_sel), 0);
      tick(1);
      chk("so_stall_mem", 32'(ib.nop_sel), 1);
      chk("so_fwd_mem", 32'(ib.fwd_sel), 0);
      tick(1);
      chk("so_stall_wb", 32'(ib.ifid_le), 0);
      chk("so_fwd_wb", 32'(ib.fwd_sel), 0);
      tick(1);
      chk("so_released", 32'(ib.pc_le), 1);
      chk("so_stall_cnt", 32'(ib.stall_cnt), 3);
      tick(1);
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      tick(3);
      // 2-bit counter, 5 stages, stall-only: five consecutive stall edges saturate at 3
      drive(2, 1, 1, 0, 4'd1, 12'h000, 3'b000, 0);
      tick(1);
      drive(2, 1, 1, 0, 4'd7, 12'h001, 3'b001, 0);
      chk("sat_stall0", 32'(ic.pc_le), 0);
      tick(3);
      chk("sat_cnt3", 32'(ic.stall_cnt), 3);
      chk("sat_still_stall", 32'(ic.pc_le), 0);
      tick(2);
      chk("sat_cnt_hold", 32'(ic.stall_cnt), 3);
      chk("sat_released", 32'(ic.pc_le), 1);
      tick(1);
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      tick(5);
      // asynchronous reset in the middle of a stall
      drive(2, 1, 1, 0, 4'd1, 12'h000, 3'b000, 0);
      tick(1);
      drive(2, 1, 1, 0, 4'd7, 12'h001, 3'b001, 0);
      chk("mid_stall", 32'(ic.pc_le), 0);
      CLR = 1'b0;
      #1;
      chk("clr_pc_le", 32'(ic.pc_le), 1);
      chk("clr_nop_sel", 32'(ic.nop_sel), 0);
      chk("clr_stall_cnt", 32'(ic.stall_cnt), 0);
      chk("clr_flush_cnt_a", 32'(ia.flush_cnt), 0);
      CLR = 1'b1;
      tick(1);
      drive(2, 1, 1, 0, 4'd9, 12'h007, 3'b001, 0);
      chk("post_clr_shift", 32'(ic.pc_le), 0);
      tick(1);
      chk("post_clr_cnt", 32'(ic.stall_cnt), 1);
      drive(-1, 0, 0, 0, 0, 0, 0, 0);
      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
